rx_frame_scheduler: RTL

Read-side sequencer for the Rx ring buffer. It detects committed frames by comparing the write-side commit pointer with its own read pointer. For each frame it fetches the header word, computes the frame length in qwords, and issues DMA burst requests to the host-DMA engine. When all bursts are done it commits the new read address and raises `rd_addr_updated`. It sits between the Rx buffer read port and the DMA/TLP engine.

---
 rtl/rx_frame_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_scheduler.sv
// rx_frame_scheduler: read-side sequencer for the Rx ring buffer. It fetches each
// committed frame's header, splits the frame into DMA bursts that never cross the
// ring end, then commits the new read pointer and strobes rd_addr_updated for HOLD cycles.
// Optional macro RX_LEN_CHECK_EN: frames with byte count 0 or > MAX_FRAME_BYTES are
// dropped without DMA (header + timestamp skipped) and counted in bad_frames.
// Ports: clk/reset_n (async, active-low); enable; commited_wr_address (writer commit ptr);
//   mem_rd_addr/mem_rd_en/mem_rd_data (buffer read port, RD_LAT latency);
//   dma_req/dma_addr/dma_qwords/dma_ack/dma_done (burst request handshake);
//   commited_rd_address/rd_addr_updated (commit result + strobe);
//   frames_sent/bad_frames (counters); busy (not IDLE).
module rx_frame_scheduler #(
  parameter int AW              = 15,
  parameter int MAX_BURST       = 16,
  parameter int RD_LAT          = 2,
  parameter int HOLD            = 4,
  parameter int MAX_FRAME_BYTES = 9600
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [AW-1:0] commited_wr_address,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_en,
  input  logic [63:0]   mem_rd_data,
  output logic          dma_req,
  output logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_qwords,
  input  logic          dma_ack,
  input  logic          dma_done,
  output logic [AW-1:0] commited_rd_address,
  output logic          rd_addr_updated,
  output logic [31:0]   frames_sent,
  output logic [31:0]   bad_frames,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_WAIT, S_CALC, S_REQ, S_XFER, S_COMMIT, S_HOLD
  } state_t;

  localparam logic [AW:0] RING    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] BURST_W = (AW+1)'(MAX_BURST);

  state_t        state, state_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW-1:0] cur, cur_nxt;
  logic [AW-1:0] remaining, remaining_nxt;
  logic [15:0]   hdr_bytes, hdr_bytes_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [AW-1:0] mem_rd_addr_nxt;
  logic          mem_rd_en_nxt;
  logic [AW-1:0] commited_rd_address_nxt;
  logic          rd_addr_updated_nxt;
  logic [31:0]   frames_sent_nxt;
  logic [16:0]   len17;
  logic [AW:0]   to_end;
  logic [AW:0]   burst_w;
  logic          unused_ok;

`ifdef RX_LEN_CHECK_EN
  logic          skip, skip_nxt;
  logic [31:0]   bad_cnt, bad_cnt_nxt;
`endif

  // Frame length in qwords: payload rounded up plus header and timestamp words.
  assign len17  = (({1'b0, hdr_bytes} + 17'd7) >> 3) + 17'd2;
  // Distance to the ring end caps a burst so it never wraps mid-request.
  assign to_end = RING - {1'b0, cur};

  always_comb begin
    burst_w = {1'b0, remaining};
    if (burst_w > BURST_W) burst_w = BURST_W;
    if (burst_w > to_end)  burst_w = to_end;
  end

  // Request fields derive from registers that do not change in REQ, so they stay stable.
  assign dma_req    = (state == S_REQ);
  assign dma_addr   = dma_req ? cur : '0;
  assign dma_qwords = dma_req ? burst_w[7:0] : 8'd0;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      rd_ptr              <= '0;
      cur                 <= '0;
      remaining           <= '0;
      hdr_bytes           <= '0;
      cnt                 <= '0;
      mem_rd_addr         <= '0;
      mem_rd_en           <= 1'b0;
      commited_rd_address <= '0;
      rd_addr_updated     <= 1'b0;
      frames_sent         <= '0;
`ifdef RX_LEN_CHECK_EN
      skip                <= 1'b0;
      bad_cnt             <= '0;
`endif
    end else begin
      state               <= state_nxt;
      rd_ptr              <= rd_ptr_nxt;
      cur                 <= cur_nxt;
      remaining           <= remaining_nxt;
      hdr_bytes           <= hdr_bytes_nxt;
      cnt                 <= cnt_nxt;
      mem_rd_addr         <= mem_rd_addr_nxt;
      mem_rd_en           <= mem_rd_en_nxt;
      commited_rd_address <= commited_rd_address_nxt;
      rd_addr_updated     <= rd_addr_updated_nxt;
      frames_sent         <= frames_sent_nxt;
`ifdef RX_LEN_CHECK_EN
      skip                <= skip_nxt;
      bad_cnt             <= bad_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt               = state;
    rd_ptr_nxt              = rd_ptr;
    cur_nxt                 = cur;
    remaining_nxt           = remaining;
    hdr_bytes_nxt           = hdr_bytes;
    cnt_nxt                 = cnt;
    mem_rd_addr_nxt         = mem_rd_addr;
    mem_rd_en_nxt           = 1'b0;
    commited_rd_address_nxt = commited_rd_address;
    rd_addr_updated_nxt     = rd_addr_updated;
    frames_sent_nxt         = frames_sent;
`ifdef RX_LEN_CHECK_EN
    skip_nxt                = skip;
    bad_cnt_nxt             = bad_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (enable && (commited_wr_address != rd_ptr)) begin
          mem_rd_en_nxt   = 1'b1;
          mem_rd_addr_nxt = rd_ptr;
          cnt_nxt         = 8'd0;
          state_nxt       = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        // cnt is 0 in the cycle mem_rd_en is high; data is valid RD_LAT cycles later.
        if (cnt == 8'(RD_LAT)) begin
          hdr_bytes_nxt = mem_rd_data[47:32];
          state_nxt     = S_CALC;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_CALC: begin
        remaining_nxt = AW'(len17);
        cur_nxt       = rd_ptr;
        state_nxt     = S_REQ;
`ifdef RX_LEN_CHECK_EN
        skip_nxt = 1'b0;
        if ((hdr_bytes == 16'd0) || (hdr_bytes > 16'(MAX_FRAME_BYTES))) begin
          cur_nxt     = rd_ptr + AW'(2);
          skip_nxt    = 1'b1;
          bad_cnt_nxt = bad_cnt + 32'd1;
          state_nxt   = S_COMMIT;
        end
`endif
      end
      S_REQ: begin
        if (dma_ack) state_nxt = S_XFER;
      end
      S_XFER: begin
        if (dma_done) begin
          cur_nxt       = cur + AW'(burst_w);
          remaining_nxt = remaining - AW'(burst_w);
          state_nxt     = ((remaining - AW'(burst_w)) != '0) ? S_REQ : S_COMMIT;
        end
      end
      S_COMMIT: begin
        rd_ptr_nxt              = cur;
        commited_rd_address_nxt = cur;
        rd_addr_updated_nxt     = 1'b1;
        cnt_nxt                 = 8'd0;
        state_nxt               = S_HOLD;
`ifdef RX_LEN_CHECK_EN
        if (!skip) frames_sent_nxt = frames_sent + 32'd1;
`else
        frames_sent_nxt = frames_sent + 32'd1;
`endif
      end
      S_HOLD: begin
        // rd_addr_updated went high entering HOLD; drop it after HOLD cycles in this state.
        if (cnt == 8'(HOLD - 1)) begin
          rd_addr_updated_nxt = 1'b0;
          state_nxt           = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef RX_LEN_CHECK_EN
  assign bad_frames = bad_cnt;
  assign unused_ok  = ^{mem_rd_data[63:48], mem_rd_data[31:0]};
`else
  assign bad_frames = '0;
  assign unused_ok  = ^{mem_rd_data[63:48], mem_rd_data[31:0], 32'(MAX_FRAME_BYTES)};
`endif

endmodule
